// File: rtl/life_ctrl.sv
// Sequencing controller for the 8x8 Game-of-Life datapath: seed load, run/step/pause,
// generation counting and auto-halt. Define LIFE_CYCLE_DETECT_EN to add period-2 detection.
module life_ctrl #(
  parameter int EVOLVE_LAT = 1,
  parameter int GEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [63:0]      seed,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_pause,
  input  logic [GEN_W-1:0] gen_limit,
  output logic [63:0]      dp_grid,
  output logic [1:0]       dp_mode,
  input  logic [63:0]      dp_grid_evolved,
  output logic [63:0]      grid_out,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic [2:0]       halt_reason
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_LOAD   = 2'b01;
  localparam logic [1:0] MODE_EVOLVE = 2'b10;

  localparam logic [2:0] RSN_NONE    = 3'b000;
  localparam logic [2:0] RSN_LIMIT   = 3'b001;
  localparam logic [2:0] RSN_STILL   = 3'b010;
  localparam logic [2:0] RSN_EXTINCT = 3'b011;
  localparam logic [2:0] RSN_PERIOD2 = 3'b100;

  // WAIT counter counts down from LAT-2 to 0, giving LAT-1 WAIT cycles
  localparam int WAIT_W = (EVOLVE_LAT > 2) ? $clog2(EVOLVE_LAT - 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = (EVOLVE_LAT > 1) ? WAIT_W'(EVOLVE_LAT - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PAUSED, S_ISSUE, S_WAIT, S_HALT
  } state_t;

  state_t            r_state;
  logic [63:0]       r_seed;
  logic              r_run;
  logic              r_pend;
  logic [WAIT_W-1:0] r_wait;
`ifdef LIFE_CYCLE_DETECT_EN
  logic [63:0]       r_prev;
`endif

  logic              w_accept;
  logic              w_capture;
  logic              w_pause;
  logic [GEN_W-1:0]  w_cnt_nxt;
  logic              w_period2;
  logic [2:0]        w_reason;

  assign w_accept  = seed_valid && seed_ready;
  assign w_capture = (r_state == S_ISSUE && EVOLVE_LAT == 1) ||
                     (r_state == S_WAIT && r_wait == '0);
  assign w_pause   = r_pend || cmd_pause;
  assign w_cnt_nxt = (&gen_count) ? gen_count : gen_count + 1'b1;

`ifdef LIFE_CYCLE_DETECT_EN
  assign w_period2 = (w_cnt_nxt > GEN_W'(1)) && (dp_grid_evolved == r_prev) &&
                     (dp_grid_evolved != grid_out);
`else
  assign w_period2 = 1'b0;
`endif

  // Halt checks operate on the freshly evolved grid and incremented count
  always_comb begin
    w_reason = RSN_NONE;
    if (dp_grid_evolved == 64'd0)                              w_reason = RSN_EXTINCT;
    else if (dp_grid_evolved == grid_out)                      w_reason = RSN_STILL;
    else if (w_period2)                                        w_reason = RSN_PERIOD2;
    else if (gen_limit != '0 && w_cnt_nxt == gen_limit)        w_reason = RSN_LIMIT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_seed      <= '0;
      r_run       <= 1'b0;
      r_pend      <= 1'b0;
      r_wait      <= '0;
      seed_ready  <= 1'b0;
      dp_grid     <= '0;
      dp_mode     <= MODE_HOLD;
      grid_out    <= '0;
      gen_count   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      halt_reason <= RSN_NONE;
`ifdef LIFE_CYCLE_DETECT_EN
      r_prev      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_PAUSED, S_HALT: begin
          seed_ready <= 1'b1;
          if (w_accept) begin
            r_seed     <= seed;
            dp_grid    <= seed;
            dp_mode    <= MODE_LOAD;
            seed_ready <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            r_state    <= S_LOAD;
          end else if (r_state == S_PAUSED && !cmd_pause && (cmd_step || cmd_run)) begin
            r_run      <= !cmd_step;
            r_pend     <= 1'b0;
            dp_grid    <= grid_out;
            dp_mode    <= MODE_EVOLVE;
            seed_ready <= 1'b0;
            busy       <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_LOAD: begin
          grid_out    <= r_seed;
          gen_count   <= '0;
          halt_reason <= RSN_NONE;
          r_run       <= 1'b0;
          r_pend      <= 1'b0;
          dp_grid     <= r_seed;
          dp_mode     <= MODE_HOLD;
          busy        <= 1'b0;
          seed_ready  <= 1'b1;
          r_state     <= S_PAUSED;
`ifdef LIFE_CYCLE_DETECT_EN
          r_prev      <= '0;
`endif
        end
        S_ISSUE, S_WAIT: begin
          if (cmd_pause) r_pend <= 1'b1;
          if (w_capture) begin
            grid_out  <= dp_grid_evolved;
            gen_count <= w_cnt_nxt;
            dp_grid   <= dp_grid_evolved;
            r_pend    <= 1'b0;
`ifdef LIFE_CYCLE_DETECT_EN
            r_prev    <= grid_out;
`endif
            if (w_reason != RSN_NONE) begin
              halt_reason <= w_reason;
              r_run       <= 1'b0;
              dp_mode     <= MODE_HOLD;
              busy        <= 1'b0;
              done        <= 1'b1;
              seed_ready  <= 1'b1;
              r_state     <= S_HALT;
            end else if (r_run && !w_pause) begin
              dp_mode <= MODE_EVOLVE;
              r_state <= S_ISSUE;
            end else begin
              r_run      <= 1'b0;
              dp_mode    <= MODE_HOLD;
              busy       <= 1'b0;
              seed_ready <= 1'b1;
              r_state    <= S_PAUSED;
            end
          end else if (r_state == S_ISSUE) begin
            dp_mode <= MODE_HOLD;
            r_wait  <= WAIT_INIT;
            r_state <= S_WAIT;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_life_ctrl.sv
// Self-checking bench for life_ctrl: directed scenarios plus random seeds checked against
// a generation-by-generation Life reference model; includes a latency-accurate datapath model.
module tb_life_ctrl;

  localparam int LAT = 3;
  localparam logic [63:0] BLOCK  = 64'h0000_0000_1818_0000;
  localparam logic [63:0] SINGLE = 64'h0000_0000_0800_0000;
  localparam logic [63:0] BLINK  = 64'h0000_0000_0038_0000;
  localparam logic [63:0] VERT   = 64'h0000_0000_1010_1000;

  logic        clk, reset;
  logic        seed_valid, seed_ready;
  logic [63:0] seed;
  logic        cmd_run, cmd_step, cmd_pause;
  logic [15:0] gen_limit;
  logic [63:0] dp_grid, dp_grid_evolved, grid_out;
  logic [1:0]  dp_mode;
  logic [15:0] gen_count;
  logic        busy, done;
  logic [2:0]  halt_reason;

  int n_vec = 0;
  int n_err = 0;

  life_ctrl #(.EVOLVE_LAT(LAT), .GEN_W(16)) dut (
    .clk(clk), .reset(reset),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed(seed),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_pause(cmd_pause),
    .gen_limit(gen_limit),
    .dp_grid(dp_grid), .dp_mode(dp_mode), .dp_grid_evolved(dp_grid_evolved),
    .grid_out(grid_out), .gen_count(gen_count),
    .busy(busy), .done(done), .halt_reason(halt_reason)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Conway rules on an 8x8 board with dead cells beyond the edges
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
              cnt += int'(g[8 * (r + dr) + (c + dc)]);
        n[8 * r + c] = (cnt == 3) || (g[8 * r + c] && cnt == 2);
      end
    return n;
  endfunction

  // Datapath stand-in: result valid LAT-1 cycles after the issue cycle, junk otherwise
  logic [63:0] dp_pipe [LAT-1];
  always @(posedge clk) begin
    dp_pipe[0] <= (dp_mode == 2'b10) ? life(dp_grid) : {$urandom, $urandom};
    for (int i = 1; i < LAT - 1; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_grid_evolved = dp_pipe[LAT-2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [63:0] s, input int lim,
                       output logic [63:0] g, output int n, output int rsn);
    logic [63:0] cur, back, nxt;
    cur = s; back = '0; n = 0; rsn = 0;
    while (rsn == 0 && n < 1000) begin
      nxt = life(cur);
      n++;
      if (nxt == 64'd0) rsn = 3;
      else if (nxt == cur) rsn = 2;
`ifdef LIFE_CYCLE_DETECT_EN
      else if (n >= 2 && nxt == back) rsn = 4;
`endif
      else if (lim != 0 && n == lim) rsn = 1;
      back = cur;
      cur  = nxt;
    end
    g = cur;
  endtask

  task automatic load(input logic [63:0] s);
    int n;
    n = 0;
    while (!seed_ready && n < 20) begin @(negedge clk); n++; end
    seed = s; seed_valid = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0;
    chk("load_mode", dp_mode, 2'b01);
    chk("load_dpgrid", dp_grid, s);
    @(negedge clk);
    chk("load_grid", grid_out, s);
    chk("load_cnt", gen_count, 0);
  endtask

  task automatic run_to_done(input int max, output int cyc);
    cmd_run = 1'b1;
    @(negedge clk);
    cmd_run = 1'b0;
    cyc = 1;
    while (!done && cyc < max) begin @(negedge clk); cyc++; end
    if (!done) chk("done_timeout", done, 1'b1);
  endtask

  task automatic run_check(input logic [63:0] s, input int lim);
    logic [63:0] eg;
    int en, er, cyc;
    model(s, lim, eg, en, er);
    load(s);
    gen_limit = 16'(lim);
    run_to_done(1 + en * LAT + 20, cyc);
    chk("run_cyc", cyc, 1 + en * LAT);
    chk("run_grid", grid_out, eg);
    chk("run_cnt", gen_count, en);
    chk("run_rsn", halt_reason, er);
    chk("run_busy", busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, busy_n;
    logic [63:0] rs;
    reset = 1'b1; seed_valid = 1'b0; seed = '0;
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_pause = 1'b0; gen_limit = '0;
    repeat (2) @(negedge clk);
    chk("rst_grid", grid_out, 0);
    chk("rst_dpgrid", dp_grid, 0);
    chk("rst_ctl", {gen_count, dp_mode, busy, done, halt_reason, seed_ready}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", seed_ready, 1'b1);
    chk("idle_ctl", {gen_count, dp_mode, busy, done, halt_reason}, 0);

    // IDLE ignores commands
    cmd_run = 1'b1; @(negedge clk); cmd_run = 1'b0; @(negedge clk);
    chk("idle_cmd", busy, 1'b0);

    // Block: still life after one generation
    load(BLOCK);
    run_to_done(40, cyc);
    chk("blk_cyc", cyc, 1 + LAT);
    chk("blk_rsn", halt_reason, 3'b010);
    chk("blk_cnt", gen_count, 1);
    chk("blk_done", done, 1'b1);

    // HALT ignores commands
    cmd_step = 1'b1; @(negedge clk); cmd_step = 1'b0; @(negedge clk);
    chk("halt_cmd", {busy, done}, 2'b01);

    // Single cell dies
    load(SINGLE);
    run_to_done(40, cyc);
    chk("one_grid", grid_out, 0);
    chk("one_rsn", halt_reason, 3'b011);
    chk("one_cnt", gen_count, 1);

    // Blinker with a limit of 5
    load(BLINK);
    gen_limit = 16'd5;
    run_to_done(60, cyc);
`ifdef LIFE_CYCLE_DETECT_EN
    chk("blk5_rsn", halt_reason, 3'b100);
    chk("blk5_cnt", gen_count, 2);
    chk("blk5_grid", grid_out, BLINK);
`else
    chk("blk5_rsn", halt_reason, 3'b001);
    chk("blk5_cnt", gen_count, 5);
    chk("blk5_grid", grid_out, VERT);
`endif

    // Three single steps, spaced 4 cycles
    load(BLINK);
    gen_limit = '0;
    for (int s = 0; s < 3; s++) begin
      cmd_step = 1'b1;
      busy_n = 0;
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        if (i == 1) begin
          cmd_step = 1'b0;
          chk("step_mode", dp_mode, 2'b10);
        end
        busy_n += int'(busy);
      end
      chk("step_busy", busy_n, LAT);
    end
    chk("step_cnt", gen_count, 3);
    chk("step_grid", grid_out, VERT);
    chk("step_state", {seed_ready, busy, done}, 3'b100);

    // Pause inside the WAIT of generation 3
    load(BLINK);
    cmd_run = 1'b1;
    @(negedge clk);
    cmd_run = 1'b0;
    repeat (7) @(negedge clk);
    chk("pause_wait", {dp_mode, busy}, 3'b001);
    cmd_pause = 1'b1;
    @(negedge clk);
    cmd_pause = 1'b0;
    repeat (6) @(negedge clk);
    chk("pause_cnt", gen_count, 3);
    chk("pause_grid", grid_out, VERT);
    chk("pause_state", {seed_ready, busy, done}, 3'b100);

    // Reset during WAIT
    cmd_run = 1'b1;
    @(negedge clk);
    cmd_run = 1'b0;
    @(negedge clk);
    chk("rw_wait", {dp_mode, busy}, 3'b001);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_grid", grid_out, 0);
    chk("rw_dpgrid", dp_grid, 0);
    chk("rw_ctl", {gen_count, dp_mode, busy, done, halt_reason, seed_ready}, 0);
    @(negedge clk);

    // Seed beats a same-cycle run
    load(BLINK);
    seed = BLOCK; seed_valid = 1'b1; cmd_run = 1'b1;
    @(negedge clk);
    seed_valid = 1'b0; cmd_run = 1'b0;
    chk("race_mode", dp_mode, 2'b01);
    repeat (6) @(negedge clk);
    chk("race_grid", grid_out, BLOCK);
    chk("race_idle", {gen_count, busy, done}, 0);

    // Random seeds against the reference model
    for (int k = 0; k < 14; k++) begin
      rs = {$urandom & $urandom, $urandom & $urandom};
      run_check(rs, int'($urandom_range(1, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
